// File: rtl/gcd_scheduler.sv
// gcd_scheduler: one shared iterative Euclidean GCD engine serving N_REQ round-robin requesters
module gcd_scheduler #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 40,
    parameter int MAX_ITER = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    input  logic [N_REQ*WIDTH-1:0]     req_x_i,
    input  logic [N_REQ*WIDTH-1:0]     req_y_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [$clog2(N_REQ)-1:0]   resp_id_o,
    output logic [WIDTH-1:0]           resp_gcd_o,
    output logic                       resp_err_o,
    output logic                       busy_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_ITER + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, gcd_q, gcd_d, rem;
    logic [CW-1:0]    iter_q, iter_d;
    logic [IW-1:0]    id_q, id_d, rr_q, rr_d, gnt_idx;
    logic             gnt_found, err_q, err_d, resp_valid_q, busy_q;

    // Restoring long division keeping only the remainder; b==0 is never consumed.
    function automatic logic [WIDTH-1:0] rem_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            r = {r[WIDTH-1:0], a[i]};
            if (r >= {1'b0, b}) r = r - {1'b0, b};
        end
        return r[WIDTH-1:0];
    endfunction

    assign rem = rem_f(x_q, y_q);

    // Pick the first valid requester at or after rr_q, wrapping upward.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_found && req_valid_i[(int'(rr_q) + k) % N_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    assign req_ready_o = (state_q == IDLE && gnt_found) ? (N_REQ'(1) << gnt_idx) : '0;

    // Next-state: accept in IDLE, one remainder step per cycle in ITER, hold result in DONE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        id_d    = id_q;
        rr_d    = rr_q;
        iter_d  = iter_q;
        gcd_d   = gcd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (gnt_found) begin
                state_d = ITER;
                x_d     = req_x_i[gnt_idx*WIDTH +: WIDTH];
                y_d     = req_y_i[gnt_idx*WIDTH +: WIDTH];
                id_d    = gnt_idx;
                iter_d  = '0;
                rr_d    = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            ITER: if (y_q == '0) begin
                state_d = DONE;
                gcd_d   = x_q;
                err_d   = 1'b0;
            end else if (iter_q == CW'(MAX_ITER)) begin
                state_d = DONE;
                gcd_d   = '0;
                err_d   = 1'b1;
            end else begin
                x_d    = y_q;
                y_d    = rem;
                iter_d = iter_q + 1'b1;
            end
            DONE: if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; response flags are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            id_q         <= '0;
            rr_q         <= '0;
            iter_q       <= '0;
            gcd_q        <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            id_q         <= id_d;
            rr_q         <= rr_d;
            iter_q       <= iter_d;
            gcd_q        <= gcd_d;
            err_q        <= err_d;
            resp_valid_q <= (state_d == DONE);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = id_q;
    assign resp_gcd_o   = gcd_q;
    assign resp_err_o   = err_q;
    assign busy_o       = busy_q;
endmodule

// File: tb/tb_gcd_scheduler.sv
// tb_gcd_scheduler: directed and randomized checks of the shared GCD scheduler
module tb_gcd_scheduler;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req_valid = '0, req_ready;
    logic [159:0] req_x = '0, req_y = '0;
    logic         resp_valid, resp_ready = 1'b0, resp_err, busy;
    logic [1:0]   resp_id;
    logic [39:0]  resp_gcd;
    logic [3:0]   c_req_valid = '0, c_req_ready;
    logic [159:0] c_req_x = '0, c_req_y = '0;
    logic         c_resp_valid, c_resp_ready = 1'b0, c_resp_err, c_busy;
    logic [1:0]   c_resp_id;
    logic [39:0]  c_resp_gcd;
    int           errors = 0, checks = 0;

    always #5 clk = ~clk;

    gcd_scheduler #(.N_REQ(4), .WIDTH(40), .MAX_ITER(64)) dut (
        .clk_i(clk), .reset_ni(reset_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_x_i(req_x), .req_y_i(req_y), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_id_o(resp_id), .resp_gcd_o(resp_gcd), .resp_err_o(resp_err), .busy_o(busy));

    gcd_scheduler #(.N_REQ(4), .WIDTH(40), .MAX_ITER(4)) u_cap (
        .clk_i(clk), .reset_ni(reset_n), .req_valid_i(c_req_valid), .req_ready_o(c_req_ready),
        .req_x_i(c_req_x), .req_y_i(c_req_y), .resp_valid_o(c_resp_valid), .resp_ready_i(c_resp_ready),
        .resp_id_o(c_resp_id), .resp_gcd_o(c_resp_gcd), .resp_err_o(c_resp_err), .busy_o(c_busy));

    // Binary (Stein) gcd as an independent reference
    function automatic logic [39:0] ref_gcd(input logic [39:0] a, input logic [39:0] b);
        int sh = 0;
        logic [39:0] t;
        if (a == 0) return b;
        if (b == 0) return a;
        while (a[0] == 1'b0 && b[0] == 1'b0) begin a = a >> 1; b = b >> 1; sh++; end
        while (a[0] == 1'b0) a = a >> 1;
        while (b != 0) begin
            while (b[0] == 1'b0) b = b >> 1;
            if (a > b) begin t = a; a = b; b = t; end
            b = b - a;
        end
        return a << sh;
    endfunction

    task automatic drive_req(input int id, input logic [39:0] x, input logic [39:0] y);
        req_valid[id] = 1'b1;
        req_x[id*40 +: 40] = x;
        req_y[id*40 +: 40] = y;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!resp_valid && n < 200) begin @(negedge clk); #1; n++; end
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_resp: resp_valid=%b after %0d cycles, required 1", resp_valid, n);
        end
    endtask

    task automatic handshake;
        resp_ready = 1'b1;
        @(negedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic do_job(input int id, input logic [39:0] x, input logic [39:0] y,
                          input logic [39:0] eg, input logic ee, input int elat);
        logic [3:0] er;
        int n;
        er = 4'b0001 << id;
        @(negedge clk); drive_req(id, x, y); #1;
        checks++;
        if (req_ready !== er) begin
            errors++;
            $display("FAIL job_ready(%0d,%0d): req_ready=%b required %b", x, y, req_ready, er);
        end
        @(negedge clk); #1;
        req_valid = '0;
        wait_valid(n);
        checks++;
        if (n !== elat || resp_id !== 2'(id) || resp_gcd !== eg || resp_err !== ee) begin
            errors++;
            $display("FAIL job(%0d,%0d): lat=%0d id=%0d gcd=%0d err=%b required lat=%0d id=%0d gcd=%0d err=%b",
                     x, y, n, resp_id, resp_gcd, resp_err, elat, id, eg, ee);
        end
        handshake;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL job_release: resp_valid=%b busy=%b required 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_id, resp_gcd, resp_err, busy} !== 49'd0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b id=%0d gcd=%0d err=%b busy=%b required all 0",
                     req_ready, resp_valid, resp_id, resp_gcd, resp_err, busy);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        do_job(2, 40'd12, 40'd8, 40'd4, 1'b0, 3);
        do_job(0, 40'd8, 40'd12, 40'd4, 1'b0, 4);
        do_job(1, 40'd7, 40'd0, 40'd7, 1'b0, 1);
        do_job(3, 40'd0, 40'd0, 40'd0, 1'b0, 1);
        do_job(3, 40'd0, 40'd9, 40'd9, 1'b0, 2);
        do_job(0, 40'hFF_FFFF_FFFF, 40'h80_0000_0000, 40'd1, 1'b0, 4);
    endtask

    task automatic test_round_robin;
        logic [39:0] eg [4] = '{40'd6, 40'd1, 40'd9, 40'd0};
        logic [3:0] er;
        int n;
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); #1; reset_n = 1'b1;
        drive_req(0, 40'd48, 40'd18);
        drive_req(1, 40'd17, 40'd5);
        drive_req(2, 40'd0, 40'd9);
        drive_req(3, 40'd0, 40'd0);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rr_first: req_ready=%b required 0001", req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            wait_valid(n);
            checks++;
            if (resp_id !== 2'(k % 4) || resp_gcd !== eg[k % 4] || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL rr_resp%0d: id=%0d gcd=%0d err=%b required id=%0d gcd=%0d err=0",
                         k, resp_id, resp_gcd, resp_err, k % 4, eg[k % 4]);
            end
            handshake;
            er = 4'b0001 << ((k + 1) % 4);
            checks++;
            if (req_ready !== er) begin
                errors++;
                $display("FAIL rr_next%0d: req_ready=%b required %b", k, req_ready, er);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk); drive_req(1, 40'd30, 40'd12); #1;
        @(negedge clk); #1; req_valid = '0;
        wait_valid(n);
        drive_req(3, 40'd100, 40'd75);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({resp_valid, resp_id, resp_gcd, resp_err, req_ready, busy} !== {1'b1, 2'd1, 40'd6, 1'b0, 4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b id=%0d gcd=%0d err=%b ready=%b busy=%b required 1 1 6 0 0000 1",
                         i, resp_valid, resp_id, resp_gcd, resp_err, req_ready, busy);
            end
            @(negedge clk);
        end
        #1;
        handshake;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_release: resp_valid=%b req_ready=%b required 0 1000", resp_valid, req_ready);
        end
        @(negedge clk); #1;
        req_valid = '0;
        wait_valid(n);
        checks++;
        if (resp_id !== 2'd3 || resp_gcd !== 40'd25 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_next: id=%0d gcd=%0d err=%b required 3 25 0", resp_id, resp_gcd, resp_err);
        end
        handshake;
    endtask

    task automatic test_cap;
        int n = 0;
        @(negedge clk);
        c_req_valid = 4'b0001;
        c_req_x[39:0] = 40'd89;
        c_req_y[39:0] = 40'd55;
        #1;
        checks++;
        if (c_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL cap_ready: req_ready=%b required 0001", c_req_ready);
        end
        @(negedge clk); #1;
        c_req_valid = '0;
        while (!c_resp_valid && n < 50) begin @(negedge clk); #1; n++; end
        checks++;
        if (n !== 5 || c_resp_valid !== 1'b1 || c_resp_err !== 1'b1 || c_resp_gcd !== 40'd0 || c_resp_id !== 2'd0) begin
            errors++;
            $display("FAIL cap: lat=%0d valid=%b err=%b gcd=%0d id=%0d required 5 1 1 0 0",
                     n, c_resp_valid, c_resp_err, c_resp_gcd, c_resp_id);
        end
        c_resp_ready = 1'b1;
        @(negedge clk); #1;
        c_resp_ready = 1'b0;
        checks++;
        if (c_resp_valid !== 1'b0 || c_busy !== 1'b0) begin
            errors++;
            $display("FAIL cap_release: valid=%b busy=%b required 0 0", c_resp_valid, c_busy);
        end
    endtask

    task automatic test_reset_mid_job;
        logic seen = 1'b0;
        int n;
        @(negedge clk); drive_req(1, 40'd89, 40'd55);
        @(negedge clk); #1; req_valid = '0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({req_ready, resp_valid, resp_id, resp_gcd, resp_err, busy} !== 49'd0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b valid=%b id=%0d gcd=%0d err=%b busy=%b required all 0",
                     req_ready, resp_valid, resp_id, resp_gcd, resp_err, busy);
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
            if (resp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_quiet: response or busy seen=%b required 0", seen);
        end
        @(negedge clk);
        drive_req(0, 40'd9, 40'd6);
        drive_req(2, 40'd10, 40'd4);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset_grant: req_ready=%b required 0001", req_ready);
        end
        @(negedge clk); #1;
        req_valid[0] = 1'b0;
        wait_valid(n);
        checks++;
        if (resp_id !== 2'd0 || resp_gcd !== 40'd3) begin
            errors++;
            $display("FAIL mid_reset_job0: id=%0d gcd=%0d required 0 3", resp_id, resp_gcd);
        end
        handshake;
        @(negedge clk); #1;
        req_valid = '0;
        wait_valid(n);
        checks++;
        if (resp_id !== 2'd2 || resp_gcd !== 40'd2) begin
            errors++;
            $display("FAIL mid_reset_job2: id=%0d gcd=%0d required 2 2", resp_id, resp_gcd);
        end
        handshake;
    endtask

    task automatic test_random;
        int done = 0;
        int n, id;
        logic [39:0] x, y, g;
        logic [3:0] er;
        for (int j = 0; j < 1000; j++) begin
            id = $urandom_range(0, 3);
            x = ($urandom_range(0, 3) == 0) ? 40'($urandom_range(0, 20)) : 40'({$urandom, $urandom});
            y = ($urandom_range(0, 3) == 0) ? 40'($urandom_range(0, 20)) : 40'({$urandom, $urandom});
            g = ref_gcd(x, y);
            er = 4'b0001 << id;
            @(negedge clk); drive_req(id, x, y);
            resp_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (req_ready !== er) begin
                errors++;
                $display("FAIL rand_ready%0d: req_ready=%b required %b", j, req_ready, er);
            end
            @(negedge clk); #1;
            req_valid = '0;
            wait_valid(n);
            checks++;
            if (resp_id !== 2'(id) || resp_gcd !== g || resp_err !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d(%0d,%0d): id=%0d gcd=%0d err=%b required %0d %0d 0",
                         j, x, y, resp_id, resp_gcd, resp_err, id, g);
            end
            resp_ready = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
            if (resp_valid) begin
                handshake;
                done++;
            end
            checks++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_release%0d: resp_valid=%b busy=%b required 0 0", j, resp_valid, busy);
            end
        end
        checks++;
        if (done !== 1000) begin
            errors++;
            $display("FAIL rand_count: responses=%0d required 1000", done);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_round_robin;
        test_backpressure;
        test_cap;
        test_reset_mid_job;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
